pon_burst_scheduler: RTL and testbench
======================================

// Module: pon_burst_scheduler
// PURPOSE
//  Burst-mode PON TX scheduler. Sits downstream of the debug VIO stage and consumes
//  its preamble_length / burst_length / burst_period / b2bcontrol controls.
//  Emits periodic upstream bursts: preamble words, then payload pulled from a
//  streaming source, then idle gap. Drives the GT TX datapath and the laser-enable.
//  Config is shadowed at each period start, so VIO edits never corrupt a burst in flight.
// PARAMETERS
//  DATA_W        32            TX word width (payload and tx_data)
//  PREAMBLE_WORD 32'hAAAA_AAAA word sent during preamble
//  IDLE_WORD     32'h0000_0000 word sent in gap and on payload underrun
// PORTS
//  hb0_gtwiz_userclk_tx_usrclk2_int   in  1      sole clock (GT TX usrclk2)
//  hb0_gtwiz_reset_n                  in  1      asynchronous, active-low reset
//  b2bcontrol                         in  1      scheduler enable
//  preamble_length_vio_int            in  32     preamble words P
//  burst_length_vio_int               in  32     payload words B
//  burst_period_vio_int               in  32     period in cycles T
//  payload_tdata                      in  DATA_W payload word
//  payload_tvalid                     in  1      payload word valid
//  payload_tready                     out 1      payload accepted this cycle
//  tx_data                            out DATA_W word to GT TX
//  tx_valid                           out 1      tx_data inside burst (preamble or payload)
//  laser_en                           out 1      burst-mode laser enable (== tx_valid)
//  burst_start                        out 1      1-cycle pulse, first preamble cycle on tx_*
//  cfg_err                            out 1      sticky: illegal/truncating config seen
//  burst_count                        out 32     bursts started, wraps at 2^32
//  underrun_count                     out 16     payload cycles with no tvalid, saturates
// BEHAVIOUR
//  Reset (async assert, sync deassert via clock): state IDLE, all outputs 0,
//   tx_data=IDLE_WORD, counters 0, shadow regs 0.
//  States: IDLE, PREAMBLE, PAYLOAD, GAP. Period counter cnt (32b), 0 at period start.
//  Period start (IDLE with b2bcontrol=1, or GAP/any state at cnt==Ts-1 with b2bcontrol=1):
//   latch Ps/Bs/Ts from VIO inputs, cnt<=0, burst_count+1, next state PREAMBLE
//   (PAYLOAD if Ps==0; GAP if Ps==0 and Bs==0).
//  Legality check on latch: Ts==0 or Ps+Bs==0 -> stay IDLE, set cfg_err.
//   Ps+Bs > Ts (33-bit sum) -> proceed, set cfg_err, burst truncated at cnt==Ts-1.
//  PREAMBLE for cnt 0..Ps-1; PAYLOAD for cnt Ps..Ps+Bs-1; GAP until cnt==Ts-1.
//  payload_tready = (state==PAYLOAD), combinational from state register.
//  TX outputs registered, 1-cycle latency vs scheduling state:
//   PREAMBLE -> tx_data=PREAMBLE_WORD; PAYLOAD & tvalid -> payload_tdata;
//   PAYLOAD & !tvalid -> IDLE_WORD, underrun_count+1 (sat 16'hFFFF), slot consumed;
//   GAP/IDLE -> IDLE_WORD, tx_valid=0.
//  burst_start registered alongside first tx_valid of each burst.
//  b2bcontrol deassert: current period completes; at cnt==Ts-1 go IDLE, no new latch.
//  b2bcontrol reassert while IDLE: PREAMBLE on next edge.
//  Reset mid-burst: tx_valid/laser_en drop asynchronously; no partial-burst resume.
//  cfg_err clears only on reset.
// STRUCTURE
//  Shared package pon_pkg: state enum encoding, PREAMBLE_WORD/IDLE_WORD defaults,
//   counter widths. One sub-module natural: pon_burst_timer (cnt, shadow regs,
//   legality check, phase boundaries); top holds FSM, TX output regs, statistics.
// TESTING
//  P=4,B=8,T=20,en=1, tvalid=1 -> 4 PREAMBLE_WORD, 8 payload words in order, 8 idle; repeats every 20; burst_start every 20.
//  P=0,B=5,T=10 -> payload on first tx_valid cycle; burst_start coincides; 5 valid of 10.
//  P=4,B=20,T=16 -> cfg_err=1, tx_valid 16 of 16 cycles, 12 payload words per burst.
//  Change P mid-burst (P 4->2 at cnt=6) -> current burst unaffected; next burst 2 preamble words.
//  tvalid low 3 cycles inside payload -> 3 IDLE_WORD with tx_valid=1, underrun_count=3, burst length unchanged.
//  en low at cnt=3, T=0 latch, reset at cnt=5 -> burst finishes then IDLE; T=0 stays IDLE+cfg_err; reset clears all outputs immediately.

Source files
------------

// File: rtl/pon_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : pon_pkg                                                       |
// | Brief  : Shared state encoding, word defaults and widths for PON TX.   |
// | Rev    : 1.0                                                           |
// +------------------------------------------------------------------------+
package pon_pkg;

  localparam int CNT_W  = 32;
  localparam int UCNT_W = 16;

  localparam logic [31:0] PREAMBLE_WORD_DEF = 32'hAAAA_AAAA;
  localparam logic [31:0] IDLE_WORD_DEF     = 32'h0000_0000;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_PREAMBLE = 2'd1;
  localparam logic [1:0] ST_PAYLOAD  = 2'd2;
  localparam logic [1:0] ST_GAP      = 2'd3;

  // Phase of a period position given preamble end p and payload end pb.
  function automatic logic [1:0] phase_at(input logic [CNT_W:0] pos,
                                          input logic [CNT_W:0] p,
                                          input logic [CNT_W:0] pb);
    if (pos < p)       return ST_PREAMBLE;
    else if (pos < pb) return ST_PAYLOAD;
    else               return ST_GAP;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pon_burst_scheduler_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : pon_burst_scheduler_if                                        |
// | Brief  : Payload stream and GT TX bundle of the burst scheduler.       |
// | Rev    : 1.0                                                           |
// +------------------------------------------------------------------------+
interface pon_burst_scheduler_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] payload_tdata;
  logic              payload_tvalid;
  logic              payload_tready;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              laser_en;
  logic              burst_start;

  modport master (
    output payload_tdata, payload_tvalid,
    input  payload_tready, tx_data, tx_valid, laser_en, burst_start
  );

  modport slave (
    input  payload_tdata, payload_tvalid,
    output payload_tready, tx_data, tx_valid, laser_en, burst_start
  );
endinterface
`default_nettype wire

// File: rtl/pon_burst_timer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : pon_burst_timer                                               |
// | Brief  : Period counter, config shadows, legality and phase decode.    |
// | Rev    : 1.0                                                           |
// +------------------------------------------------------------------------+
module pon_burst_timer
  import pon_pkg::*;
(
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             i_active,
  input  wire logic             i_en,
  input  wire logic [CNT_W-1:0] i_p,
  input  wire logic [CNT_W-1:0] i_b,
  input  wire logic [CNT_W-1:0] i_t,
  output logic                  o_period_start,
  output logic                  o_period_end,
  output logic                  o_cfg_illegal,
  output logic                  o_cfg_trunc,
  output logic                  o_first_slot,
  output logic [1:0]            o_first_phase,
  output logic [1:0]            o_next_phase
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_ps;
  logic [CNT_W-1:0] r_bs;
  logic [CNT_W-1:0] r_ts;
  logic [CNT_W:0]   w_in_sum;
  logic [CNT_W:0]   w_sh_sum;
  logic [CNT_W:0]   w_cnt_nxt;

  // 33-bit sums so P+B never wraps past T.
  assign w_in_sum  = {1'b0, i_p} + {1'b0, i_b};
  assign w_sh_sum  = {1'b0, r_ps} + {1'b0, r_bs};
  assign w_cnt_nxt = {1'b0, r_cnt} + (CNT_W+1)'(1);

  assign o_period_end   = i_active && (r_cnt == (r_ts - CNT_W'(1)));
  assign o_period_start = i_en && (!i_active || o_period_end);
  assign o_cfg_illegal  = (i_t == '0) || (w_in_sum == '0);
  assign o_cfg_trunc    = w_in_sum > {1'b0, i_t};
  assign o_first_slot   = i_active && (r_cnt == '0);
  assign o_first_phase  = phase_at('0, {1'b0, i_p}, w_in_sum);
  assign o_next_phase   = phase_at(w_cnt_nxt, {1'b0, r_ps}, w_sh_sum);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_ps  <= '0;
      r_bs  <= '0;
      r_ts  <= '0;
    end else if (o_period_start) begin
      r_cnt <= '0;
      r_ps  <= i_p;
      r_bs  <= i_b;
      r_ts  <= i_t;
    end else if (o_period_end) begin
      r_cnt <= '0;
    end else if (i_active) begin
      r_cnt <= w_cnt_nxt[CNT_W-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/pon_burst_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : pon_burst_scheduler                                           |
// | Brief  : Periodic burst-mode PON TX: preamble, payload, idle gap.      |
// | Rev    : 1.0                                                           |
// +------------------------------------------------------------------------+
module pon_burst_scheduler
  import pon_pkg::*;
#(
  parameter int                DATA_W        = 32,
  parameter logic [DATA_W-1:0] PREAMBLE_WORD = DATA_W'(PREAMBLE_WORD_DEF),
  parameter logic [DATA_W-1:0] IDLE_WORD     = DATA_W'(IDLE_WORD_DEF)
) (
  input  wire logic              hb0_gtwiz_userclk_tx_usrclk2_int,
  input  wire logic              hb0_gtwiz_reset_n,
  input  wire logic              b2bcontrol,
  input  wire logic [CNT_W-1:0]  preamble_length_vio_int,
  input  wire logic [CNT_W-1:0]  burst_length_vio_int,
  input  wire logic [CNT_W-1:0]  burst_period_vio_int,
  pon_burst_scheduler_if.slave   bus,
  output logic                   cfg_err,
  output logic [CNT_W-1:0]       burst_count,
  output logic [UCNT_W-1:0]      underrun_count
);

  logic              r_state;
  logic [1:0]        r_st;
  logic              w_active;
  logic              w_start;
  logic              w_end;
  logic              w_illegal;
  logic              w_trunc;
  logic              w_first_slot;
  logic [1:0]        w_first_phase;
  logic [1:0]        w_next_phase;
  logic              w_in_burst;
  logic [DATA_W-1:0] r_tx_data;
  logic              r_tx_valid;
  logic              r_burst_start;
  logic              r_cfg_err;
  logic [CNT_W-1:0]  r_burst_count;
  logic [UCNT_W-1:0] r_underrun;

  assign w_active   = (r_st != ST_IDLE);
  assign w_in_burst = (r_st == ST_PREAMBLE) || (r_st == ST_PAYLOAD);
  assign r_state    = w_active;

  pon_burst_timer u_timer (
    .clk            (hb0_gtwiz_userclk_tx_usrclk2_int),
    .rst_n          (hb0_gtwiz_reset_n),
    .i_active       (r_state),
    .i_en           (b2bcontrol),
    .i_p            (preamble_length_vio_int),
    .i_b            (burst_length_vio_int),
    .i_t            (burst_period_vio_int),
    .o_period_start (w_start),
    .o_period_end   (w_end),
    .o_cfg_illegal  (w_illegal),
    .o_cfg_trunc    (w_trunc),
    .o_first_slot   (w_first_slot),
    .o_first_phase  (w_first_phase),
    .o_next_phase   (w_next_phase)
  );

  // A period boundary with enable low falls through to IDLE.
  always_ff @(posedge hb0_gtwiz_userclk_tx_usrclk2_int or negedge hb0_gtwiz_reset_n) begin
    if (!hb0_gtwiz_reset_n) begin
      r_st <= ST_IDLE;
    end else if (w_start) begin
      r_st <= w_illegal ? ST_IDLE : w_first_phase;
    end else if (w_end) begin
      r_st <= ST_IDLE;
    end else if (w_active) begin
      r_st <= w_next_phase;
    end
  end

  always_ff @(posedge hb0_gtwiz_userclk_tx_usrclk2_int or negedge hb0_gtwiz_reset_n) begin
    if (!hb0_gtwiz_reset_n) begin
      r_tx_data     <= IDLE_WORD;
      r_tx_valid    <= 1'b0;
      r_burst_start <= 1'b0;
      r_cfg_err     <= 1'b0;
      r_burst_count <= '0;
      r_underrun    <= '0;
    end else begin
      r_tx_valid    <= w_in_burst;
      r_burst_start <= w_first_slot && w_in_burst;
      case (r_st)
        ST_PREAMBLE: r_tx_data <= PREAMBLE_WORD;
        ST_PAYLOAD:  r_tx_data <= bus.payload_tvalid ? bus.payload_tdata : IDLE_WORD;
        default:     r_tx_data <= IDLE_WORD;
      endcase
      // An underrun still consumes its payload slot.
      if ((r_st == ST_PAYLOAD) && !bus.payload_tvalid && (r_underrun != '1)) begin
        r_underrun <= r_underrun + UCNT_W'(1);
      end
      if (w_start && !w_illegal) begin
        r_burst_count <= r_burst_count + CNT_W'(1);
      end
      if (w_start && (w_illegal || w_trunc)) begin
        r_cfg_err <= 1'b1;
      end
    end
  end

  assign bus.payload_tready = (r_st == ST_PAYLOAD);
  assign bus.tx_data        = r_tx_data;
  assign bus.tx_valid       = r_tx_valid;
  assign bus.laser_en       = r_tx_valid;
  assign bus.burst_start    = r_burst_start;
  assign cfg_err            = r_cfg_err;
  assign burst_count        = r_burst_count;
  assign underrun_count     = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_pon_burst_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : tb_pon_burst_scheduler                                        |
// | Brief  : Slot-queue reference model bench for the burst scheduler.     |
// | Rev    : 1.0                                                           |
// +------------------------------------------------------------------------+
module tb_pon_burst_scheduler;

  localparam logic [31:0] PRE_W = 32'hAAAA_AAAA;
  localparam logic [31:0] IDL_W = 32'h0000_0000;
  localparam logic [1:0]  K_NONE = 2'd0;
  localparam logic [1:0]  K_PRE  = 2'd1;
  localparam logic [1:0]  K_PAY  = 2'd2;
  localparam logic [1:0]  K_GAP  = 2'd3;

  typedef struct packed {
    logic [1:0] kind;
    logic       first;
  } slot_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [31:0] p = '0;
  logic [31:0] b = '0;
  logic [31:0] t = '0;
  logic        cfg_err;
  logic [31:0] burst_count;
  logic [15:0] underrun_count;

  pon_burst_scheduler_if #(.DATA_W(32)) bus ();

  pon_burst_scheduler #(.DATA_W(32)) dut (
    .hb0_gtwiz_userclk_tx_usrclk2_int (clk),
    .hb0_gtwiz_reset_n                (rst_n),
    .b2bcontrol                       (en),
    .preamble_length_vio_int          (p),
    .burst_length_vio_int             (b),
    .burst_period_vio_int             (t),
    .bus                              (bus.slave),
    .cfg_err                          (cfg_err),
    .burst_count                      (burst_count),
    .underrun_count                   (underrun_count)
  );

  always #5 clk = ~clk;

  // Each period is expanded into T slots; one slot is consumed per clock.
  slot_t       sched[$];
  logic        e_txv, e_bs, e_cfg, e_ready;
  logic [31:0] e_txd, e_bc;
  logic [15:0] e_und;
  logic [115:0] exp_v;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  wire [115:0] obs = {bus.tx_valid, bus.laser_en, bus.burst_start, bus.payload_tready,
                      cfg_err, bus.tx_data, burst_count, underrun_count};

  task automatic pack_exp();
    exp_v = {e_txv, e_txv, e_bs, e_ready, e_cfg, e_txd, e_bc, e_und};
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    sched.delete();
    e_txv = 0; e_bs = 0; e_cfg = 0; e_ready = 0;
    e_txd = IDL_W; e_bc = '0; e_und = '0;
    pack_exp();
  endtask

  task automatic release_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step();
    slot_t  cur;
    slot_t  s;
    longint sum;
    @(posedge clk);
    cur = '0;
    if (sched.size() > 0) cur = sched.pop_front();
    e_bs = cur.first;
    case (cur.kind)
      K_PRE: begin e_txv = 1; e_txd = PRE_W; end
      K_PAY: begin
        e_txv = 1;
        e_txd = bus.payload_tvalid ? bus.payload_tdata : IDL_W;
        if (!bus.payload_tvalid && e_und != 16'hFFFF) e_und = e_und + 16'd1;
      end
      default: begin e_txv = 0; e_txd = IDL_W; e_bs = 0; end
    endcase
    if (sched.size() == 0 && en) begin
      sum = longint'(p) + longint'(b);
      if (t == 0 || sum == 0) begin
        e_cfg = 1;
      end else begin
        if (sum > longint'(t)) e_cfg = 1;
        e_bc = e_bc + 32'd1;
        for (longint i = 0; i < longint'(t); i++) begin
          s.kind  = (i < longint'(p)) ? K_PRE : ((i < sum) ? K_PAY : K_GAP);
          s.first = (i == 0);
          sched.push_back(s);
        end
      end
    end
    e_ready = (sched.size() > 0) && (sched[0].kind == K_PAY);
    @(negedge clk);
    cyc++;
    pack_exp();
  endtask

  task automatic test_reset();
    @(negedge clk);
    #2 assert_reset();
    #1;
    checks++;
    if (obs !== {5'b0, IDL_W, 32'd0, 16'd0}) begin
      errors++;
      $display("FAIL reset_state got=%h exp=%h", obs, {5'b0, IDL_W, 32'd0, 16'd0});
    end
    release_reset();
    en = 0;
    repeat (3) begin
      step();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d got=%h exp=%h", cyc, obs, exp_v);
      end
    end
  endtask

  task automatic test_basic();
    p = 4; b = 8; t = 20; en = 1; bus.payload_tvalid = 1;
    repeat (60) begin
      bus.payload_tdata = $urandom();
      step();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL basic cyc=%0d got=%h exp=%h", cyc, obs, exp_v);
      end
    end
    checks++;
    if (burst_count !== 32'd3) begin
      errors++;
      $display("FAIL basic_burst_count got=%0d exp=3", burst_count);
    end
  endtask

  task automatic test_zero_preamble();
    int nvalid = 0;
    @(negedge clk); #2 assert_reset(); release_reset();
    p = 0; b = 5; t = 10; en = 1; bus.payload_tvalid = 1;
    repeat (30) begin
      bus.payload_tdata = $urandom();
      step();
      if (bus.tx_valid === 1'b1) nvalid++;
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL zero_preamble cyc=%0d got=%h exp=%h", cyc, obs, exp_v);
      end
    end
    checks++;
    if (nvalid != 15) begin
      errors++;
      $display("FAIL zero_preamble_valid_count got=%0d exp=15", nvalid);
    end
  endtask

  task automatic test_truncate();
    int nvalid = 0;
    @(negedge clk); #2 assert_reset(); release_reset();
    p = 4; b = 20; t = 16; en = 1; bus.payload_tvalid = 1;
    repeat (48) begin
      bus.payload_tdata = $urandom();
      step();
      if (bus.tx_valid === 1'b1) nvalid++;
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL truncate cyc=%0d got=%h exp=%h", cyc, obs, exp_v);
      end
    end
    checks++;
    if (cfg_err !== 1'b1 || nvalid != 47) begin
      errors++;
      $display("FAIL truncate_cfg got cfg_err=%b valid=%0d exp cfg_err=1 valid=47", cfg_err, nvalid);
    end
  endtask

  task automatic test_cfg_change();
    @(negedge clk); #2 assert_reset(); release_reset();
    p = 4; b = 8; t = 20; en = 1; bus.payload_tvalid = 1;
    for (int i = 0; i < 47; i++) begin
      if (i == 7) p = 2;
      bus.payload_tdata = $urandom();
      step();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL cfg_change cyc=%0d got=%h exp=%h", cyc, obs, exp_v);
      end
    end
  endtask

  task automatic test_underrun();
    int drops = 0;
    @(negedge clk); #2 assert_reset(); release_reset();
    p = 4; b = 8; t = 20; en = 1;
    repeat (40) begin
      bus.payload_tvalid = 1;
      if (bus.payload_tready === 1'b1 && drops < 3) begin
        bus.payload_tvalid = 0;
        drops++;
      end
      bus.payload_tdata = $urandom();
      step();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL underrun cyc=%0d got=%h exp=%h", cyc, obs, exp_v);
      end
    end
    checks++;
    if (underrun_count !== 16'd3) begin
      errors++;
      $display("FAIL underrun_count got=%0d exp=3", underrun_count);
    end
  endtask

  task automatic test_disable();
    @(negedge clk); #2 assert_reset(); release_reset();
    p = 4; b = 8; t = 20; en = 1; bus.payload_tvalid = 1;
    for (int i = 0; i < 39; i++) begin
      if (i == 4) en = 0;
      if (i == 34) begin t = 0; en = 1; end
      bus.payload_tdata = $urandom();
      step();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL disable cyc=%0d got=%h exp=%h", cyc, obs, exp_v);
      end
    end
    checks++;
    if (bus.tx_valid !== 1'b0 || cfg_err !== 1'b1 || burst_count !== 32'd1) begin
      errors++;
      $display("FAIL disable_end got valid=%b cfg=%b bc=%0d exp valid=0 cfg=1 bc=1",
               bus.tx_valid, cfg_err, burst_count);
    end
    @(negedge clk); #2 assert_reset(); release_reset();
    t = 20; en = 1;
    repeat (6) step();
    #2 assert_reset();
    #1;
    checks++;
    if (bus.tx_valid !== 1'b0 || bus.laser_en !== 1'b0 || burst_count !== 32'd0 || bus.tx_data !== IDL_W) begin
      errors++;
      $display("FAIL midburst_reset got valid=%b laser=%b bc=%0d data=%h exp 0 0 0 %h",
               bus.tx_valid, bus.laser_en, burst_count, bus.tx_data, IDL_W);
    end
    release_reset();
  endtask

  task automatic test_random();
    @(negedge clk); #2 assert_reset(); release_reset();
    repeat (8) begin
      p = $urandom_range(0, 6);
      b = $urandom_range(0, 10);
      t = $urandom_range(0, 24);
      en = 1;
      repeat (60) begin
        if ($urandom_range(0, 15) == 0) en = ~en;
        bus.payload_tvalid = ($urandom_range(0, 3) != 0);
        bus.payload_tdata  = $urandom();
        step();
        checks++;
        if (obs !== exp_v) begin
          errors++;
          $display("FAIL random cyc=%0d p=%0d b=%0d t=%0d got=%h exp=%h", cyc, p, b, t, obs, exp_v);
        end
      end
    end
  endtask

  initial begin
    bus.payload_tdata  = '0;
    bus.payload_tvalid = 1'b0;
    assert_reset();
    test_reset();
    test_basic();
    test_zero_preamble();
    test_truncate();
    test_cfg_change();
    test_underrun();
    test_disable();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
